// File: rtl/peak_hold_tracker.sv
// Purpose: track the largest ADC sample (with hysteresis) and its servo position across one sweep.
// Latency: every output is registered and reflects the inputs sampled on the previous rising edge.
// Backpressure: none; samples are accepted every cycle SAMPLE_VALID is high while sweeping.
module peak_hold_tracker #(
  parameter int DATA_W = 12,
  parameter int POS_W  = 8,
  parameter int THRESH = 4,
  parameter int CNT_W  = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              STOP,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] SAMPLE,
  input  logic [POS_W-1:0]  POS,
  output logic [DATA_W-1:0] MAX_VAL,
  output logic [POS_W-1:0]  MAX_POS,
  output logic [CNT_W-1:0]  SAMPLE_CNT,
  output logic              UPDATED,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Threshold widened by one bit so the peak+threshold sum can never wrap.
  localparam logic [DATA_W:0] THRESH_EXT = (DATA_W+1)'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t              r_state;
  logic [DATA_W-1:0]   r_max_val;
  logic [POS_W-1:0]    r_max_pos;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_updated;
  logic                r_busy;
  logic                r_done;

  logic [DATA_W:0]     w_sum;
  logic                w_first;
  logic                w_beats;
  logic                w_load;
  logic                w_cnt_sat;

  // Replacement decision: first sample of a sweep always loads; later ones
  // must clear the stored peak by at least THRESH. A sum above the DATA_W range
  // can never be reached by any sample, so no update is possible there.
  always_comb begin
    w_sum     = {1'b0, r_max_val} + THRESH_EXT;
    w_first   = (r_cnt == '0);
    w_beats   = ({1'b0, SAMPLE} >= w_sum);
    w_load    = SAMPLE_VALID && (w_first || w_beats);
    w_cnt_sat = (r_cnt == CNT_MAX);
  end

  // Sweep control FSM together with the peak, position and counter registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_max_val <= '0;
      r_max_pos <= '0;
      r_cnt     <= '0;
      r_updated <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // UPDATED is a single-cycle pulse; it is only raised on an actual load.
      r_updated <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_state   <= ST_SWEEP;
            r_max_val <= '0;
            r_max_pos <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end

        ST_SWEEP: begin
          if (START) begin
            // Restart wins over STOP and discards the same-cycle sample.
            r_max_val <= '0;
            r_max_pos <= '0;
            r_cnt     <= '0;
          end else begin
            // A sample arriving with STOP is still counted and compared.
            if (SAMPLE_VALID) begin
              if (!w_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
              end
              if (w_load) begin
                r_max_val <= SAMPLE;
                r_max_pos <= POS;
                r_updated <= 1'b1;
              end
            end
            if (STOP) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Results are frozen until the controller starts a new sweep.
          if (START) begin
            r_state   <= ST_SWEEP;
            r_max_val <= '0;
            r_max_pos <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign MAX_VAL    = r_max_val;
  assign MAX_POS    = r_max_pos;
  assign SAMPLE_CNT = r_cnt;
  assign UPDATED    = r_updated;
  assign BUSY       = r_busy;
  assign DONE       = r_done;

endmodule

// File: doc/peak_hold_tracker.md
Name: peak_hold_tracker

Overview:
- Parametrised successor to the single max-voltage storage register.
- Over one tracker sweep, captures the largest ADC sample and the servo position where it occurred.
- Applies a minimum-improvement threshold (hysteresis) so ADC noise cannot move the stored peak.
- Sits between the ADC sample stream and the servo controller. At end of sweep the controller reads MAX_POS to steer the panel.

Parameters:
DATA_W, 12, width of ADC samples and stored peak
POS_W, 8, width of servo position tag
THRESH, 4, minimum increase over stored peak needed to replace it; legal range 1 to 2^DATA_W-1
CNT_W, 10, width of accepted-sample counter

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  synchronous active-low reset
START  in  1  begin/restart sweep (single-cycle pulse)
STOP  in  1  end sweep (single-cycle pulse)
SAMPLE_VALID  in  1  SAMPLE/POS valid this cycle
SAMPLE  in  DATA_W  raw ADC value
POS  in  POS_W  servo position associated with SAMPLE
MAX_VAL  out  DATA_W  stored peak value
MAX_POS  out  POS_W  position of stored peak
SAMPLE_CNT  out  CNT_W  samples accepted this sweep, saturating
UPDATED  out  1  one-cycle pulse: peak replaced on previous edge
BUSY  out  1  high in SWEEP
DONE  out  1  high in DONE state

Behaviour:
- All state and outputs are registered. Every change appears on the edge after the causing input.
- Reset (RST_N=0 at a rising edge) puts the block in IDLE with every output at 0: MAX_VAL, MAX_POS, SAMPLE_CNT, UPDATED, BUSY, DONE.
- Reset overrides all other inputs, including mid-sweep; the partial sweep result is discarded.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - START=1: go to SWEEP, clear MAX_VAL/MAX_POS/SAMPLE_CNT, BUSY=1.
  - STOP and SAMPLE_VALID are ignored.
- SWEEP, SAMPLE_VALID=1:
  - SAMPLE_CNT increments and saturates at 2^CNT_W-1.
  - If SAMPLE_CNT==0 (first sample), load MAX_VAL=SAMPLE and MAX_POS=POS unconditionally; UPDATED=1 next cycle.
  - Otherwise compute MAX_VAL+THRESH in DATA_W+1 bits, with no wrap. If SAMPLE >= that sum, load SAMPLE/POS; UPDATED=1 next cycle.
  - If the sum exceeds 2^DATA_W-1, no update is possible.
  - Equal or smaller samples never update, so the earliest position wins ties.
- SWEEP, STOP=1 (START=0):
  - Go to DONE: BUSY=0, DONE=1.
  - A SAMPLE_VALID in the same cycle is fully processed (compare, count, possible update) before the results freeze.
- SWEEP, START=1:
  - Restart: clear MAX_VAL/MAX_POS/SAMPLE_CNT, stay in SWEEP.
  - The same-cycle sample is discarded.
  - START has priority over STOP.
- DONE:
  - MAX_VAL, MAX_POS, SAMPLE_CNT are held and DONE stays 1.
  - SAMPLE_VALID and STOP are ignored.
  - START=1: go to SWEEP with clear, as from IDLE; DONE=0, BUSY=1.
- UPDATED is 0 in every cycle where no load occurred, including the restart/clear cycle.
- A sweep with zero samples ends in DONE with MAX_VAL=0, MAX_POS=0, SAMPLE_CNT=0.
- POS is captured only together with an accepted update and is otherwise don't-care.

Test Plan:
- Reset/idle: RST_N=0 for 2 cycles, then SAMPLE_VALID=1 with SAMPLE=0x300 while idle -> all outputs 0, state IDLE.
- Threshold: defaults, START, then samples (val,pos) (100,1),(103,2),(104,3),(200,4),(199,5), STOP -> UPDATED pulses after samples 1, 3, 4 only; DONE=1, MAX_VAL=200, MAX_POS=4, SAMPLE_CNT=5.
- Saturation edge: DATA_W=12, samples 4093 then 4095 -> no update (4093+4 > 4095), MAX_VAL=4093. Then restart with samples 4091, 4095 -> update, MAX_VAL=4095.
- Simultaneous events: STOP and SAMPLE_VALID(300,9) in the same cycle with stored peak 100 -> DONE, MAX_VAL=300, MAX_POS=9. START+STOP in the same SWEEP cycle -> remain SWEEP, outputs cleared.
- Reset mid-sweep: after 3 samples (peak 500), pulse RST_N=0 -> next cycle IDLE, all outputs 0; a later START/sample(10,1)/STOP gives MAX_VAL=10.
- Counter saturation: CNT_W=3, 10 samples -> SAMPLE_CNT stays 7. Sweep START then STOP with no samples -> DONE, all values 0.
